uart_ctrl: RTL
==============

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter ADDR_DATA, 16'hBF00, address of UART data register.
REQ-002 SHALL have parameter ADDR_STAT, 16'hBF01, address of UART status register.
REQ-003 SHALL have parameter PULSE_CYC, 2, cycles rdn/wrn held low (1..15).
REQ-004 SHALL have parameter TIMEOUT, 1023, max cycles waiting on tbre/tsre.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 uci_clk  in  1  system clock.
REQ-007 uci_rst  in  1  asynchronous reset, active low.
REQ-008 uci_req  in  1  access request from mem stage, held until uco_done.
REQ-009 uci_we  in  1  1=write, 0=read.
REQ-010 uci_addr  in  16  access address.
REQ-011 uci_wdata  in  16  write data; only bits [7:0] used.
REQ-012 uco_rdata  out  16  read result, valid while uco_done=1.
REQ-013 uco_done  out  1  one-cycle completion pulse.
REQ-014 uco_busy  out  1  pause request to scheduler.
REQ-015 uco_bus_own  out  1  controller owns ram1 data bus (top forces ram1_en=1).
REQ-016 ucio_data  inout  16  shared ram1/UART data bus.
REQ-017 uci_tbre, uci_tsre, uci_data_ready  in  1 each  UART status pins.
REQ-018 uco_wrn, uco_rdn  out  1 each  UART strobes, active low.
REQ-019 uco_timeout  out  1  sticky write-timeout flag.

Function
REQ-020 States SHALL be IDLE, ST_RD, RD_WAIT, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, WR_TBRE, WR_TSRE, DONE.
REQ-021 In IDLE with uci_req=1, addr=ADDR_STAT, we=0 -> ST_RD; addr=ADDR_STAT, we=1 -> DONE (write discarded); addr=ADDR_DATA -> RD_WAIT or WR_SETUP per uci_we; any other address SHALL be ignored (no state change, busy=0).
REQ-022 ST_RD SHALL last one cycle, latch rdata={14'b0, data_ready, tbre&tsre}, then DONE.
REQ-023 RD_WAIT SHALL hold until uci_data_ready=1, then RD_PULSE.
REQ-024 RD_PULSE SHALL drive rdn=0 for exactly PULSE_CYC cycles, sample rdata={8'h00, ucio_data[7:0]} on the last low cycle, then rdn=1 and DONE.
REQ-025 WR_SETUP SHALL drive ucio_data={8'h00, wdata[7:0]} one cycle with wrn=1; WR_PULSE wrn=0 for PULSE_CYC cycles; WR_HOLD wrn=1 with data still driven one cycle.
REQ-026 WR_TBRE SHALL wait for tbre=1, then WR_TSRE SHALL wait for tsre=1, then DONE.
REQ-027 Wait counter SHALL count cycles in WR_TBRE+WR_TSRE; on reaching TIMEOUT -> DONE and set uco_timeout (stays 1 until reset).
REQ-028 DONE SHALL last one cycle with uco_done=1, then IDLE; a request present in the cycle after DONE SHALL be accepted as a new access.
REQ-029 uco_busy SHALL be combinational: 1 when uci_req=1 with a decoded address and state!=DONE, else 0.
REQ-030 ucio_data SHALL be high-Z in all states except WR_SETUP, WR_PULSE, WR_HOLD.
REQ-031 uco_bus_own SHALL be 1 in every state except IDLE.
REQ-032 rdn and wrn SHALL never be low simultaneously; both SHALL be registered (glitch-free).

Reset
REQ-033 On uci_rst=0, immediately: state=IDLE, rdn=wrn=1, ucio_data=Z, uco_rdata=0, uco_done=0, uco_bus_own=0, uco_timeout=0, counters=0, regardless of access in progress.
REQ-034 After reset release, the first access SHALL start only from IDLE on a new uci_req sample.

Structure
REQ-035 State encoding, ADDR_DATA/ADDR_STAT defaults and status bit positions (bit0 TX ready, bit1 RX ready) SHALL live in shared package uart_pkg.
REQ-036 One sub-module uart_wait_cnt (load, enable, terminal-count flag) SHALL serve both PULSE_CYC and TIMEOUT counting.

Verification
REQ-037 Status read, tbre=tsre=1, data_ready=1 -> done 2 cycles after req, rdata=16'h0003, rdn/wrn stay 1.
REQ-038 Data read, data_ready rises 5 cycles after req, bus=16'hxx5A -> rdn low exactly 2 cycles, rdata=16'h005A, busy=1 until done.
REQ-039 Write 16'h1234, tbre rises 3 cycles after WR_HOLD, tsre 4 later -> bus=16'h0034 during WR_SETUP..WR_HOLD, wrn low 2 cycles, done after tsre.
REQ-040 Write with tsre held 0 -> done after 1023 wait cycles, uco_timeout=1 and stays 1 across further accesses.
REQ-041 Reset asserted during RD_PULSE -> rdn=1, bus=Z, bus_own=0 same cycle; access to 16'h8000 -> no done, busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART controller: state encoding,
// default register addresses and status-word bit positions.
package uart_pkg;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ST_RD    = 4'd1;
  localparam logic [3:0] RD_WAIT  = 4'd2;
  localparam logic [3:0] RD_PULSE = 4'd3;
  localparam logic [3:0] WR_SETUP = 4'd4;
  localparam logic [3:0] WR_PULSE = 4'd5;
  localparam logic [3:0] WR_HOLD  = 4'd6;
  localparam logic [3:0] WR_TBRE  = 4'd7;
  localparam logic [3:0] WR_TSRE  = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  localparam logic [15:0] ADDR_DATA_DFLT = 16'hBF00;
  localparam logic [15:0] ADDR_STAT_DFLT = 16'hBF01;

  localparam int STAT_TX_BIT = 0;
  localparam int STAT_RX_BIT = 1;

  function automatic logic [15:0] status_word(input logic rx_ready, input logic tx_ready);
    logic [15:0] w;
    w = '0;
    w[STAT_RX_BIT] = rx_ready;
    w[STAT_TX_BIT] = tx_ready;
    return w;
  endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// Request/response handshake between the memory stage and the UART controller.
interface uart_ctrl_if;
  logic        uci_req;
  logic        uci_we;
  logic [15:0] uci_addr;
  logic [15:0] uci_wdata;
  logic [15:0] uco_rdata;
  logic        uco_done;
  logic        uco_busy;

  modport master (
    output uci_req, uci_we, uci_addr, uci_wdata,
    input  uco_rdata, uco_done, uco_busy
  );

  modport slave (
    input  uci_req, uci_we, uci_addr, uci_wdata,
    output uco_rdata, uco_done, uco_busy
  );
endinterface

// File: rtl/uart_wait_cnt.sv
// Loadable down-counter shared by strobe-width and tbre/tsre timeout timing.
// tc is high while the count sits at zero.
module uart_wait_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART access controller: decodes data/status addresses, times
// the rdn/wrn strobes and waits on the transmitter before completing writes.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] ADDR_DATA = ADDR_DATA_DFLT,
  parameter logic [15:0] ADDR_STAT = ADDR_STAT_DFLT,
  parameter int          PULSE_CYC = 2,
  parameter int          TIMEOUT   = 1023
) (
  input  logic        uci_clk,
  input  logic        uci_rst,
  uart_ctrl_if.slave  bus,
  output logic        uco_bus_own,
  inout  wire  [15:0] ucio_data,
  input  logic        uci_tbre,
  input  logic        uci_tsre,
  input  logic        uci_data_ready,
  output logic        uco_wrn,
  output logic        uco_rdn,
  output logic        uco_timeout
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT - 1);

  logic [3:0]       state;
  logic [7:0]       wdata_q;
  logic [15:0]      rdata_q;
  logic             addr_hit;
  logic             bus_drive;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;
  logic             unused_bits;

  assign addr_hit = (bus.uci_addr == ADDR_DATA) || (bus.uci_addr == ADDR_STAT);

  // Upper bytes of the write data and the shared bus carry nothing for the UART.
  assign unused_bits = ^{bus.uci_wdata[15:8], ucio_data[15:8]};

  always_ff @(posedge uci_clk or negedge uci_rst) begin
    if (!uci_rst) begin
      state       <= IDLE;
      uco_rdn     <= 1'b1;
      uco_wrn     <= 1'b1;
      wdata_q     <= '0;
      rdata_q     <= '0;
      uco_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.uci_req) begin
            if (bus.uci_addr == ADDR_STAT) begin
              state <= bus.uci_we ? DONE : ST_RD;
            end else if (bus.uci_addr == ADDR_DATA) begin
              if (bus.uci_we) begin
                wdata_q <= bus.uci_wdata[7:0];
                state   <= WR_SETUP;
              end else begin
                state <= RD_WAIT;
              end
            end
          end
        end
        ST_RD: begin
          rdata_q <= status_word(uci_data_ready, uci_tbre & uci_tsre);
          state   <= DONE;
        end
        RD_WAIT: begin
          if (uci_data_ready) begin
            uco_rdn <= 1'b0;
            state   <= RD_PULSE;
          end
        end
        RD_PULSE: begin
          if (cnt_tc) begin
            rdata_q <= {8'h00, ucio_data[7:0]};
            uco_rdn <= 1'b1;
            state   <= DONE;
          end
        end
        WR_SETUP: begin
          uco_wrn <= 1'b0;
          state   <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_tc) begin
            uco_wrn <= 1'b1;
            state   <= WR_HOLD;
          end
        end
        WR_HOLD: state <= WR_TBRE;
        WR_TBRE: begin
          if (uci_tbre) begin
            state <= WR_TSRE;
          end else if (cnt_tc) begin
            uco_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        WR_TSRE: begin
          if (uci_tsre) begin
            state <= DONE;
          end else if (cnt_tc) begin
            uco_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One counter times both strobe width and the transmitter wait; the load
  // happens on the edge that enters the timed state.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = PULSE_LD;
    case (state)
      RD_WAIT:  cnt_load = uci_data_ready;
      WR_SETUP: cnt_load = 1'b1;
      WR_HOLD: begin
        cnt_load = 1'b1;
        cnt_val  = TMO_LD;
      end
      RD_PULSE, WR_PULSE, WR_TBRE, WR_TSRE: cnt_en = 1'b1;
      default: ;
    endcase
  end

  uart_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (uci_clk),
    .rst_n    (uci_rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  assign bus_drive     = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
  assign ucio_data     = bus_drive ? {8'h00, wdata_q} : 16'hzzzz;
  assign uco_bus_own   = (state != IDLE);
  assign bus.uco_done  = (state == DONE);
  assign bus.uco_rdata = rdata_q;
  assign bus.uco_busy  = bus.uci_req && addr_hit && (state != DONE);

endmodule
